// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single data memory.
// One access at a time; request fields are captured at arbitration and replayed to memory.
module dmem_arbiter #(
  parameter int unsigned AW     = 8,
  parameter int unsigned DW     = 16,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_p0_req,
  input  logic          i_p0_we,
  input  logic [AW-1:0] i_p0_addr,
  input  logic [DW-1:0] i_p0_wdata,
  output logic          o_p0_gnt,
  output logic          o_p0_rvalid,
  output logic [DW-1:0] o_p0_rdata,
  input  logic          i_p1_req,
  input  logic          i_p1_we,
  input  logic [AW-1:0] i_p1_addr,
  input  logic [DW-1:0] i_p1_wdata,
  output logic          o_p1_gnt,
  output logic          o_p1_rvalid,
  output logic [DW-1:0] o_p1_rdata,
  output logic [AW-1:0] o_mem_addr,
  output logic          o_mem_rd,
  output logic          o_mem_wr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata,
  output logic          o_busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  // WAIT lasts RD_LAT cycles, so the counter starts one below the latency.
  localparam logic [1:0] LAT_INIT = (RD_LAT == 0) ? 2'd0 : 2'(RD_LAT - 1);

  logic [1:0]    r_state;
  logic          r_ptr;
  logic          r_win;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [1:0]    r_cnt;
  logic [DW-1:0] r_p0_rdata;
  logic [DW-1:0] r_p1_rdata;

  logic w_sample;
  logic w_any;
  logic w_win;
  logic w_cap;
  logic w_access;

  always_comb begin
    w_sample = (r_state == S_IDLE) || (r_state == S_RESP);
    w_any    = i_p0_req | i_p1_req;
    // Under contention the port that did not win last time goes first.
    w_win    = (i_p0_req && i_p1_req) ? ~r_ptr : i_p1_req;
    w_access = (r_state == S_ACCESS);
    w_cap    = (w_access && !r_we && (RD_LAT == 0)) ||
               ((r_state == S_WAIT) && (r_cnt == 2'd0));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_ptr      <= 1'b1;
      r_win      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_cnt      <= 2'd0;
      r_p0_rdata <= '0;
      r_p1_rdata <= '0;
    end else begin
      if (w_cap) begin
        if (r_win) begin
          r_p1_rdata <= i_mem_rdata;
        end else begin
          r_p0_rdata <= i_mem_rdata;
        end
      end

      case (r_state)
        S_IDLE, S_RESP: begin
          if (w_sample && w_any) begin
            r_win   <= w_win;
            r_ptr   <= w_win;
            r_we    <= w_win ? i_p1_we    : i_p0_we;
            r_addr  <= w_win ? i_p1_addr  : i_p0_addr;
            r_wdata <= w_win ? i_p1_wdata : i_p0_wdata;
            r_state <= S_ACCESS;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ACCESS: begin
          if (r_we) begin
            r_state <= S_IDLE;
          end else if (RD_LAT == 0) begin
            r_state <= S_RESP;
          end else begin
            r_cnt   <= LAT_INIT;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == 2'd0) begin
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_p0_gnt    = w_access && !r_win;
  assign o_p1_gnt    = w_access && r_win;
  assign o_p0_rvalid = (r_state == S_RESP) && !r_win;
  assign o_p1_rvalid = (r_state == S_RESP) && r_win;
  assign o_p0_rdata  = r_p0_rdata;
  assign o_p1_rdata  = r_p1_rdata;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_mem_wr    = w_access && r_we;
  assign o_mem_rd    = w_access && !r_we;
  assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench: four arbiters (RD_LAT 0..3) each with its own memory model.
// Stimulus queues expected grants/read responses; a negedge monitor matches them.
module tb_dmem_arbiter;

  localparam int NI = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NI-1:0] rst;
  logic          load;
  logic          mon_en = 1'b0;

  logic        p0_req [NI], p0_we [NI], p1_req [NI], p1_we [NI];
  logic [7:0]  p0_addr [NI], p1_addr [NI];
  logic [15:0] p0_wdata [NI], p1_wdata [NI];
  logic        p0_gnt [NI], p1_gnt [NI], p0_rvalid [NI], p1_rvalid [NI];
  logic [15:0] p0_rdata [NI], p1_rdata [NI];
  logic [7:0]  mem_addr [NI];
  logic        mem_rd [NI], mem_wr [NI], busy [NI];
  logic [15:0] mem_wdata [NI], mem_rdata [NI];

  int checks = 0;
  int failures = 0;

  function automatic logic [15:0] pat(input logic [7:0] a);
    return {a ^ 8'h5A, ~a};
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_lat
    logic [15:0] mem [256];
    logic [15:0] pipe [3];

    dmem_arbiter #(.AW(8), .DW(16), .RD_LAT(g)) u_dut (
      .i_clk(clk), .i_rst(rst[g]),
      .i_p0_req(p0_req[g]), .i_p0_we(p0_we[g]), .i_p0_addr(p0_addr[g]),
      .i_p0_wdata(p0_wdata[g]), .o_p0_gnt(p0_gnt[g]), .o_p0_rvalid(p0_rvalid[g]),
      .o_p0_rdata(p0_rdata[g]),
      .i_p1_req(p1_req[g]), .i_p1_we(p1_we[g]), .i_p1_addr(p1_addr[g]),
      .i_p1_wdata(p1_wdata[g]), .o_p1_gnt(p1_gnt[g]), .o_p1_rvalid(p1_rvalid[g]),
      .o_p1_rdata(p1_rdata[g]),
      .o_mem_addr(mem_addr[g]), .o_mem_rd(mem_rd[g]), .o_mem_wr(mem_wr[g]),
      .o_mem_wdata(mem_wdata[g]), .i_mem_rdata(mem_rdata[g]), .o_busy(busy[g])
    );

    // Read data is only meaningful RD_LAT cycles after a rd strobe; otherwise junk.
    always @(posedge clk) begin
      if (load) begin
        for (int k = 0; k < 256; k++) mem[k] <= pat(8'(k));
      end else if (mem_wr[g]) begin
        mem[mem_addr[g]] <= mem_wdata[g];
      end
      pipe[0] <= mem_rd[g] ? mem[mem_addr[g]] : 16'hDEAD;
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end

    if (g == 0) begin : g_async
      assign mem_rdata[g] = mem_rd[g] ? mem[mem_addr[g]] : 16'hDEAD;
    end else begin : g_sync
      assign mem_rdata[g] = pipe[g-1];
    end
  end

  typedef struct {
    int          kind;  // 0 grant, 1 read response
    int          inst;
    int          port;
    int          cyc;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];

  task automatic expect_gnt(input int i, input int p, input int c, input logic w,
                            input logic [7:0] a, input logic [15:0] d);
    exp_t e;
    e.kind = 0; e.inst = i; e.port = p; e.cyc = c; e.we = w; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic expect_rv(input int i, input int p, input int c, input logic [15:0] d);
    exp_t e;
    e.kind = 1; e.inst = i; e.port = p; e.cyc = c; e.we = 1'b0; e.addr = 8'h00; e.data = d;
    exp_q.push_back(e);
  endtask

  function automatic int find(input int k, input int i, input int p);
    foreach (exp_q[j]) begin
      if (exp_q[j].kind == k && exp_q[j].inst == i && exp_q[j].port == p) return j;
    end
    return -1;
  endfunction

  task automatic drive(input int i, input int p, input logic r, input logic w,
                       input logic [7:0] a, input logic [15:0] d);
    if (p == 0) begin
      p0_req[i] = r; p0_we[i] = w; p0_addr[i] = a; p0_wdata[i] = d;
    end else begin
      p1_req[i] = r; p1_we[i] = w; p1_addr[i] = a; p1_wdata[i] = d;
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  // Monitor: grants, read responses, rdata stability and strobe legality.
  initial begin : mon
    logic [15:0] prev_rd [NI][2];
    logic [NI-1:0] prev_rst;
    logic g_, rv_;
    logic [15:0] rd_;
    int idx;
    exp_t e;
    prev_rst = '1;
    for (int i = 0; i < NI; i++) begin
      prev_rd[i][0] = 16'h0;
      prev_rd[i][1] = 16'h0;
    end
    forever begin
      @(negedge clk);
      if (mon_en) begin
        for (int i = 0; i < NI; i++) begin
          checks++;
          if ((mem_rd[i] && mem_wr[i]) ||
              ((mem_rd[i] || mem_wr[i]) != (p0_gnt[i] || p1_gnt[i]))) begin
            failures++;
            $display("FAIL strobe inst %0d cyc %0d: got rd=%b wr=%b gnt=%b%b required strobe only with gnt",
                     i, cyc, mem_rd[i], mem_wr[i], p1_gnt[i], p0_gnt[i]);
          end
          for (int p = 0; p < 2; p++) begin
            g_  = (p == 0) ? p0_gnt[i] : p1_gnt[i];
            rv_ = (p == 0) ? p0_rvalid[i] : p1_rvalid[i];
            rd_ = (p == 0) ? p0_rdata[i] : p1_rdata[i];
            if (g_) begin
              checks++;
              idx = find(0, i, p);
              if (idx < 0) begin
                failures++;
                $display("FAIL gnt inst %0d port %0d: got grant at cyc %0d required none", i, p, cyc);
              end else begin
                e = exp_q[idx];
                exp_q.delete(idx);
                if (cyc != e.cyc || mem_addr[i] != e.addr || mem_wr[i] != e.we ||
                    mem_rd[i] != !e.we || (e.we && mem_wdata[i] != e.data)) begin
                  failures++;
                  $display("FAIL gnt inst %0d port %0d: got cyc=%0d addr=%h wr=%b rd=%b wdata=%h required cyc=%0d addr=%h we=%b wdata=%h",
                           i, p, cyc, mem_addr[i], mem_wr[i], mem_rd[i], mem_wdata[i],
                           e.cyc, e.addr, e.we, e.data);
                end
              end
            end
            if (rv_) begin
              checks++;
              idx = find(1, i, p);
              if (idx < 0) begin
                failures++;
                $display("FAIL rvalid inst %0d port %0d: got rvalid at cyc %0d required none", i, p, cyc);
              end else begin
                e = exp_q[idx];
                exp_q.delete(idx);
                if (cyc != e.cyc || rd_ !== e.data) begin
                  failures++;
                  $display("FAIL rvalid inst %0d port %0d: got cyc=%0d rdata=%h required cyc=%0d rdata=%h",
                           i, p, cyc, rd_, e.cyc, e.data);
                end
              end
            end
            if (rd_ !== prev_rd[i][p]) begin
              checks++;
              if (!rv_ && !prev_rst[i]) begin
                failures++;
                $display("FAIL rdata_hold inst %0d port %0d cyc %0d: got %h required %h",
                         i, p, cyc, rd_, prev_rd[i][p]);
              end
            end
            prev_rd[i][p] = rd_;
          end
        end
      end
      prev_rst = rst;
    end
  end

  initial begin : stim
    int n;
    int k;
    logic [7:0] a;
    rst  = '1;
    load = 1'b1;
    for (int i = 0; i < NI; i++) begin
      drive(i, 0, 1'b0, 1'b0, 8'h00, 16'h0000);
      drive(i, 1, 1'b0, 1'b0, 8'h00, 16'h0000);
    end
    step(2);
    rst    = '0;
    load   = 1'b0;
    mon_en = 1'b1;

    // Idle after reset: everything quiet and zero.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        check($sformatf("reset_ctl inst %0d cyc %0d", i, cyc),
              64'({p0_gnt[i], p1_gnt[i], p0_rvalid[i], p1_rvalid[i],
                   mem_rd[i], mem_wr[i], busy[i]}), 64'h0);
        check($sformatf("reset_data inst %0d cyc %0d", i, cyc),
              {mem_addr[i], mem_wdata[i], p0_rdata[i], p1_rdata[i]}, 64'h0);
      end
    end
    step(1);

    // p1 write then read on the RD_LAT=1 instance.
    n = cyc;
    drive(1, 1, 1'b1, 1'b1, 8'h10, 16'hBEEF);
    expect_gnt(1, 1, n + 1, 1'b1, 8'h10, 16'hBEEF);
    step(1);
    drive(1, 1, 1'b0, 1'b0, 8'h00, 16'h0000);
    step(1);
    n = cyc;
    drive(1, 1, 1'b1, 1'b0, 8'h10, 16'h0000);
    expect_gnt(1, 1, n + 1, 1'b0, 8'h10, 16'h0000);
    expect_rv(1, 1, n + 3, 16'hBEEF);
    step(1);
    drive(1, 1, 1'b0, 1'b0, 8'h00, 16'h0000);
    step(3);

    // Contention: six reads, strict alternation starting with p0.
    n = cyc;
    drive(1, 0, 1'b1, 1'b0, 8'h20, 16'h0000);
    drive(1, 1, 1'b1, 1'b0, 8'h30, 16'h0000);
    for (int t = 0; t < 6; t++) begin
      a = ((t % 2) == 1) ? 8'(8'h30 + t / 2) : 8'(8'h20 + t / 2);
      expect_gnt(1, t % 2, n + 1 + 3 * t, 1'b0, a, 16'h0000);
      expect_rv(1, t % 2, n + 3 + 3 * t, pat(a));
    end
    for (int t = 0; t < 6; t++) begin
      step(n + 2 + 3 * t - cyc);
      k = t / 2;
      if (k < 2) begin
        a = ((t % 2) == 1) ? 8'(8'h30 + k + 1) : 8'(8'h20 + k + 1);
        drive(1, t % 2, 1'b1, 1'b0, a, 16'h0000);
      end else begin
        drive(1, t % 2, 1'b0, 1'b0, 8'h00, 16'h0000);
      end
    end
    step(2);

    // Latency sweep: back-to-back p0 reads on every instance, second from RESP.
    n = cyc;
    for (int i = 0; i < NI; i++) begin
      drive(i, 0, 1'b1, 1'b0, 8'h40, 16'h0000);
      expect_gnt(i, 0, n + 1, 1'b0, 8'h40, 16'h0000);
      expect_rv(i, 0, n + 2 + i, pat(8'h40));
      expect_gnt(i, 0, n + 3 + i, 1'b0, 8'h41, 16'h0000);
      expect_rv(i, 0, n + 4 + 2 * i, pat(8'h41));
    end
    for (int t = 1; t <= 12; t++) begin
      step(1);
      for (int i = 0; i < NI; i++) begin
        if (t == 2) drive(i, 0, 1'b1, 1'b0, 8'h41, 16'h0000);
        if (t == 4 + i) drive(i, 0, 1'b0, 1'b0, 8'h00, 16'h0000);
      end
    end

    // Reset during WAIT (RD_LAT=3): read is dropped, pointer returns to favour p0.
    step(1);
    n = cyc;
    drive(3, 0, 1'b1, 1'b0, 8'h50, 16'h0000);
    expect_gnt(3, 0, n + 1, 1'b0, 8'h50, 16'h0000);
    step(1);
    drive(3, 0, 1'b0, 1'b0, 8'h00, 16'h0000);
    step(1);
    rst[3] = 1'b1;
    step(1);
    rst[3] = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(busy[3]), 64'h0);
    check("abort_strobes", 64'({mem_rd[3], mem_wr[3], p0_rvalid[3]}), 64'h0);
    drive(3, 0, 1'b1, 1'b1, 8'h60, 16'h1111);
    drive(3, 1, 1'b1, 1'b1, 8'h61, 16'h2222);
    expect_gnt(3, 0, n + 4, 1'b1, 8'h60, 16'h1111);
    expect_gnt(3, 1, n + 6, 1'b1, 8'h61, 16'h2222);
    step(2);
    drive(3, 0, 1'b0, 1'b0, 8'h00, 16'h0000);
    step(2);
    drive(3, 1, 1'b0, 1'b0, 8'h00, 16'h0000);
    step(2);

    // p0 write with p1 read arriving during ACCESS; p1 reads back the new data.
    n = cyc;
    drive(1, 0, 1'b1, 1'b1, 8'h70, 16'hCAFE);
    expect_gnt(1, 0, n + 1, 1'b1, 8'h70, 16'hCAFE);
    step(1);
    drive(1, 0, 1'b0, 1'b0, 8'h00, 16'h0000);
    drive(1, 1, 1'b1, 1'b0, 8'h70, 16'h0000);
    expect_gnt(1, 1, n + 3, 1'b0, 8'h70, 16'h0000);
    expect_rv(1, 1, n + 5, 16'hCAFE);
    step(3);
    drive(1, 1, 1'b0, 1'b0, 8'h00, 16'h0000);
    step(4);

    for (int c = 0; c < 50 && exp_q.size() != 0; c++) step(1);
    while (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL missing kind %0d inst %0d port %0d: got nothing required event at cyc %0d",
               exp_q[0].kind, exp_q[0].inst, exp_q[0].port, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish required finish before timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter that shares the single data memory (datamem) between two requesters.
- Port 0 is the control unit's load/store path. Port 1 is a debug/DMA loader that fills and inspects data memory while the CPU runs.
- Handles one access at a time, with round-robin fairness and a registered request capture.
- Sits between the requesters and datamem's addr/rd/wr/W_data/R_data interface.

Parameters:
- AW, 8, address width (matches datamem addr).
- DW, 16, data width (matches datamem W_data/R_data).
- RD_LAT, 1, cycles from the mem_rd cycle to valid mem_rdata. Legal range 0..3; 0 means asynchronous read.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- p0_req  in  1  port 0 request, held until p0_gnt.
- p0_we  in  1  port 0 write (1) / read (0).
- p0_addr  in  AW  port 0 address.
- p0_wdata  in  DW  port 0 write data.
- p0_gnt  out  1  one-cycle grant pulse (memory access cycle).
- p0_rvalid  out  1  one-cycle read-data-valid pulse.
- p0_rdata  out  DW  port 0 read data, held until its next read completes.
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: same as port 0, for port 1.
- mem_addr  out  AW  to datamem addr.
- mem_rd  out  1  to datamem rd.
- mem_wr  out  1  to datamem wr.
- mem_wdata  out  DW  to datamem W_data.
- mem_rdata  in  DW  from datamem R_data.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset is synchronous; clk and rst are the only clock/reset.
- Reset values:
  - state = IDLE.
  - all gnt, rvalid, mem_rd, mem_wr = 0.
  - mem_addr, mem_wdata, p0_rdata, p1_rdata = 0.
  - last-winner pointer = 1, so port 0 wins the first tie.
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - Requests are sampled here only.
  - If any req is high at the clock edge: select the winner, capture its we/addr/wdata into internal registers, record the winner, update the pointer, and go to ACCESS.
  - If no req is high, stay in IDLE.
- Arbitration:
  - A single requester always wins.
  - If both request, the port not equal to the pointer wins, then the pointer is set to the winner (strict alternation under contention).
- ACCESS (exactly 1 cycle):
  - The winner's gnt = 1.
  - mem_addr and mem_wdata are driven from the captured registers.
  - mem_wr = captured we; mem_rd = !captured we.
  - Write: next state is IDLE.
  - Read with RD_LAT = 0: capture mem_rdata at the end of this cycle into the winner's rdata; next state is RESP.
  - Read with RD_LAT ≥ 1: load the counter with RD_LAT-1 and go to WAIT.
- WAIT (RD_LAT cycles):
  - mem_rd = 0 and mem_wr = 0; mem_addr is held.
  - Counter decrements each cycle.
  - When the counter is 0: capture mem_rdata into the winner's rdata and go to RESP.
- RESP (1 cycle):
  - The winner's rvalid = 1.
  - Behaves as IDLE in the same cycle: samples req and may capture a new winner, entering ACCESS directly.
- Latency, with req first sampled in cycle N:
  - gnt in N+1.
  - Write completes in N+1; the next sample is at the end of N+2.
  - Read rvalid in N+2+RD_LAT.
- Handshake rules:
  - Requester holds req/we/addr/wdata stable until gnt.
  - Requester must deassert req by the cycle after gnt unless it issues a new request.
  - A req still high in IDLE/RESP is treated as a new transaction.
- rdata of the non-winning port never changes.
- rvalid is never asserted for writes.
- A req arriving while busy is ignored until IDLE/RESP. There is no queueing; the req must be held.
- Reset mid-transaction aborts the access: no gnt/rvalid follows, mem_rd/mem_wr drop in the cycle after reset is sampled, and the pointer returns to 1.
- mem_rd and mem_wr are never high simultaneously and never high outside ACCESS.

Test Plan:
- Reset, then idle 5 cycles: all outputs 0, busy = 0, mem_rd = mem_wr = 0 every cycle.
- Single write then read on p1 (RD_LAT = 1):
  - Write addr 0x10, data 0xBEEF: p1_gnt and mem_wr in N+1 with mem_addr = 0x10.
  - Read addr 0x10: p1_rvalid in N+3 with p1_rdata = 0xBEEF.
- Contention: both ports request reads every opportunity for 6 transactions.
  - Grants alternate p0, p1, p0, p1, p0, p1.
  - Each rdata equals the value preloaded at that port's address.
  - The other port's rdata is unchanged.
- RD_LAT sweep 0..3 with a p0 read: p0_rvalid exactly 2+RD_LAT cycles after the req sample; back-to-back p0 reads reissue from RESP with no idle gap.
- Reset asserted during WAIT (RD_LAT = 3): no rvalid, busy = 0 in the cycle after reset; after release, a p1/p0 tie grants p0 first.
- Write followed immediately by a p1 request arriving during ACCESS: p1 is granted in the cycle after the sample following IDLE; the p0 write data is present in memory on readback.
